// File: rtl/srrc_probe_ctrl.sv
// Impulse-response sequencer: flush SRRC filter with zeros, fire one impulse, capture the response.
// Latency: stimulus registered; capture on each sam_clk_en tick; rd_data 1 sys_clk after rd_addr.
// Backpressure: none; runs paced by sam_clk_en, start ignored while busy. Option: SRRC_PROBE_PEAK_EN.
module srrc_probe_ctrl #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              sam_clk_en,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] amplitude,
    input  logic [CNT_W-1:0]  flush_len,
    input  logic [ADDR_W:0]   cap_len,
    output logic [DATA_W-1:0] stimulus,
    input  logic [DATA_W-1:0] response,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   cap_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef SRRC_PROBE_PEAK_EN
    ,
    output logic [DATA_W-1:0] peak_mag,
    output logic [ADDR_W-1:0] peak_idx
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FLUSH   = 3'd1;
    localparam logic [2:0] S_FIRE    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [2:0]        state;
    logic [CNT_W-1:0]  flush_q;
    logic [CNT_W-1:0]  flush_cnt;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] amp_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run_start;
    logic              flush_last;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   cap_next;
    logic [ADDR_W:0]   eff_len;

    // A zero or oversized capture length means "fill the whole buffer".
    assign eff_len    = ((cap_len == '0) || (cap_len > DEPTH_L)) ? DEPTH_L : cap_len;
    // Abort outranks start; start only matters when no run is in progress.
    assign run_start  = !abort && start && ((state == S_IDLE) || (state == S_DONE));
    assign flush_last = (flush_q == '0) || (flush_cnt == flush_q - CNT_W'(1));
    // The FIRE tick stores the first response sample at index 0.
    assign wr_en      = !abort && sam_clk_en && ((state == S_FIRE) || (state == S_CAPTURE));
    assign wr_addr    = (state == S_CAPTURE) ? cap_count[ADDR_W-1:0] : '0;
    assign cap_next   = cap_count + (ADDR_W+1)'(1);

    assign busy = (state == S_FLUSH) || (state == S_FIRE) || (state == S_CAPTURE);
    assign done = (state == S_DONE);

    // Run sequencer: parameter latch, flush count, impulse, capture count.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            stimulus  <= '0;
            cap_count <= '0;
            flush_cnt <= '0;
            flush_q   <= '0;
            len_q     <= '0;
            amp_q     <= '0;
        end else if (abort) begin
            state    <= S_IDLE;
            stimulus <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    stimulus <= '0;
                    if (run_start) begin
                        state     <= S_FLUSH;
                        flush_q   <= flush_len;
                        len_q     <= eff_len;
                        amp_q     <= amplitude;
                        flush_cnt <= '0;
                        cap_count <= '0;
                    end
                end
                S_FLUSH: begin
                    if (sam_clk_en) begin
                        if (flush_last) begin
                            stimulus <= amp_q;
                            state    <= S_FIRE;
                        end else begin
                            flush_cnt <= flush_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FIRE: begin
                    if (sam_clk_en) begin
                        stimulus  <= '0;
                        cap_count <= (ADDR_W+1)'(1);
                        state     <= (len_q == (ADDR_W+1)'(1)) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (sam_clk_en) begin
                        cap_count <= cap_next;
                        if (cap_next == len_q) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    stimulus <= '0;
                end
            endcase
        end
    end

    // Capture buffer write port; contents intentionally survive reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= response;
        end
    end

    // Registered read port; a same-cycle write to the address returns the old word.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef SRRC_PROBE_PEAK_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] resp_abs;

    // Magnitude of the incoming sample; the most negative code saturates.
    always_comb begin
        resp_abs = response;
        if (response[DATA_W-1]) begin
            resp_abs = (response == MOST_NEG) ? MAX_POS : (~response + DATA_W'(1));
        end
    end

    // Peak tracker over captured samples; strict compare keeps the first index on ties.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (run_start) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (wr_en && (resp_abs > peak_mag)) begin
            peak_mag <= resp_abs;
            peak_idx <= wr_addr;
        end
    end
`endif

endmodule

// File: tb/tb_srrc_probe_ctrl.sv
// Self-checking bench for srrc_probe_ctrl: scripted runs, buffer readback through a scoreboard queue.
// Sample strobes are bench-driven, one sys_clk wide, every fourth sys_clk.
// Inputs driven and outputs sampled on the falling edge of sys_clk.
module tb_srrc_probe_ctrl;

    localparam int DATA_W = 18;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 8;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic              sam_clk_en;
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] amplitude;
    logic [CNT_W-1:0]  flush_len;
    logic [ADDR_W:0]   cap_len;
    logic [DATA_W-1:0] stimulus;
    logic [DATA_W-1:0] response;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   cap_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
`ifdef SRRC_PROBE_PEAK_EN
    logic [DATA_W-1:0] peak_mag;
    logic [ADDR_W-1:0] peak_idx;
`endif

    logic              tie;
    logic              cnt_mode;
    logic [DATA_W-1:0] resp_drv;
    logic [DATA_W-1:0] exp_buf [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int                addr_q [$];
    int                n_vec = 0;
    int                n_miscmp = 0;

    localparam logic [DATA_W-1:0] AMP = 18'h0_8000;

    assign response = tie ? stimulus : resp_drv;

    always #20 sys_clk = ~sys_clk;

    srrc_probe_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .start      (start),
        .abort      (abort),
        .amplitude  (amplitude),
        .flush_len  (flush_len),
        .cap_len    (cap_len),
        .stimulus   (stimulus),
        .response   (response),
        .busy       (busy),
        .done       (done),
        .cap_count  (cap_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`ifdef SRRC_PROBE_PEAK_EN
        ,
        .peak_mag   (peak_mag),
        .peak_idx   (peak_idx)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One sample tick: strobe high for exactly one rising edge, then three idle cycles.
    task automatic tick();
        @(negedge sys_clk);
        sam_clk_en = 1'b1;
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        if (cnt_mode) resp_drv = resp_drv + 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Readback: expected word queued when the address is driven, compared when rd_data arrives.
    task automatic readback(input int n);
        for (int a = 0; a <= n; a++) begin
            @(negedge sys_clk);
            if (exp_q.size() > 0) begin
                chk($sformatf("rd[%0d]", addr_q.pop_front()), rd_data, exp_q.pop_front());
            end
            if (a < n) begin
                rd_addr = ADDR_W'(a);
                exp_q.push_back(exp_buf[a]);
                addr_q.push_back(a);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sam_clk_en = 1'b0; start = 1'b0; abort = 1'b0;
        amplitude = '0; flush_len = '0; cap_len = '0; rd_addr = '0;
        tie = 1'b0; cnt_mode = 1'b0; resp_drv = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_stim", stimulus, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cap_count, 0);
        chk("rst_rd", rd_data, 0);
        reset = 1'b0;

        // Run 1: loopback, flush 4, capture 8.
        tie = 1'b1; amplitude = AMP; flush_len = 8'd4; cap_len = 7'd8;
        pulse_start();
        chk("r1_busy0", busy, 1);
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk($sformatf("r1_stim_t%0d", t), stimulus, (t == 4) ? AMP : 0);
            chk($sformatf("r1_done_t%0d", t), done, (t == 12) ? 1 : 0);
        end
        chk("r1_busy", busy, 0);
        chk("r1_cnt", cap_count, 8);
        for (int k = 0; k < 8; k++) exp_buf[k] = (k == 0) ? AMP : '0;
        readback(8);

        // Run 2: counting source, flush 0, cap_len 0 means the full buffer.
        tie = 1'b0; cnt_mode = 1'b1; resp_drv = '0; flush_len = 8'd0; cap_len = 7'd0;
        pulse_start();
        for (int t = 1; t <= 64; t++) tick();
        chk("r2_done_early", done, 0);
        chk("r2_cnt_early", cap_count, 63);
        tick();
        chk("r2_done", done, 1);
        chk("r2_cnt", cap_count, 64);
        for (int k = 0; k < DEPTH; k++) exp_buf[k] = DATA_W'(k + 1);
        readback(DEPTH);

        // Oversized cap_len also clamps to the buffer depth.
        resp_drv = '0; cap_len = 7'd100;
        pulse_start();
        chk("r2b_cnt_clr", cap_count, 0);
        for (int t = 1; t <= 65; t++) tick();
        chk("r2b_done", done, 1);
        chk("r2b_cnt", cap_count, 64);

        // Single-sample capture goes straight from FIRE to DONE.
        cnt_mode = 1'b0; resp_drv = 18'h2ABCD; flush_len = 8'd1; cap_len = 7'd1;
        pulse_start();
        tick();
        chk("r3_stim", stimulus, AMP);
        tick();
        chk("r3_done", done, 1);
        chk("r3_cnt", cap_count, 1);
        exp_buf[0] = 18'h2ABCD;
        readback(1);

        // Abort during capture at cap_count 3.
        cnt_mode = 1'b1; resp_drv = '0; flush_len = 8'd2; cap_len = 7'd10;
        pulse_start();
        for (int t = 1; t <= 5; t++) tick();
        chk("ab_pre_cnt", cap_count, 3);
        chk("ab_pre_busy", busy, 1);
        @(negedge sys_clk);
        abort = 1'b1; start = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0; start = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_stim", stimulus, 0);
        chk("ab_cnt", cap_count, 3);
        tick();
        chk("ab_idle_busy", busy, 0);
        chk("ab_idle_cnt", cap_count, 3);

        // start pulsed during FLUSH is ignored.
        cnt_mode = 1'b0; tie = 1'b1; flush_len = 8'd3; cap_len = 7'd2;
        pulse_start();
        tick();
        pulse_start();
        tick();
        chk("ig_stim_t2", stimulus, 0);
        tick();
        chk("ig_stim_t3", stimulus, AMP);
        tick();
        chk("ig_stim_t4", stimulus, 0);
        tick();
        chk("ig_done", done, 1);
        chk("ig_cnt", cap_count, 2);

        // start held in DONE launches a new run and clears cap_count.
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        chk("rs_busy", busy, 1);
        chk("rs_done", done, 0);
        chk("rs_cnt", cap_count, 0);
        for (int t = 1; t <= 3; t++) tick();
        start = 1'b0;
        chk("rs_fire_stim", stimulus, AMP);

        // Asynchronous reset while in FIRE.
        #5 reset = 1'b1;
        #1;
        chk("ar_stim", stimulus, 0);
        chk("ar_busy", busy, 0);
        chk("ar_cnt", cap_count, 0);
        @(negedge sys_clk);
        reset = 1'b0;
        tick();
        chk("ar_idle", busy, 0);

`ifdef SRRC_PROBE_PEAK_EN
        // Peak magnitude: first of tied maxima wins.
        tie = 1'b0; flush_len = 8'd0; cap_len = 7'd4; resp_drv = '0;
        pulse_start();
        tick();
        resp_drv = 18'd5;        tick();
        resp_drv = -18'sd20;     tick();
        resp_drv = 18'd20;       tick();
        resp_drv = 18'd7;        tick();
        chk("pk_done", done, 1);
        chk("pk_mag", peak_mag, 20);
        chk("pk_idx", peak_idx, 1);

        // Most negative sample saturates; peak clears on new run.
        cap_len = 7'd2; resp_drv = '0;
        pulse_start();
        chk("pk_clr_mag", peak_mag, 0);
        chk("pk_clr_idx", peak_idx, 0);
        tick();
        resp_drv = 18'd3;        tick();
        resp_drv = 18'h2_0000;   tick();
        chk("pk_sat_mag", peak_mag, 18'h1_FFFF);
        chk("pk_sat_idx", peak_idx, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
